// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, occupancy encoding and beat-width helper for the FIFO reader
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } occ_state_t;

   // Beat counter needs at least one bit even when a burst is a single word.
   function automatic int beat_width(input int burst_len);
      return (burst_len > 1) ? $clog2(burst_len) : 1;
   endfunction

endpackage

// File: rtl/reader_skid_buf.sv
// rtl/reader_skid_buf.sv - 2-entry skid buffer with registered valid and occupancy FSM
module reader_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready
);

   occ_state_t            r_state;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   logic                  r_valid;
   logic                  w_hs;

   assign w_hs      = r_valid & out_ready;
   assign in_ready  = (r_state != S2);
   assign out_valid = r_valid;
   assign out_data  = r_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S0;
         r_head  <= '0;
         r_tail  <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S0: begin
               if (in_valid) begin
                  r_head  <= in_data;
                  r_valid <= 1'b1;
                  r_state <= S1;
               end
            end
            S1: begin
               case ({in_valid, w_hs})
                  2'b11: r_head <= in_data;
                  2'b10: begin
                     r_tail  <= in_data;
                     r_state <= S2;
                  end
                  2'b01: begin
                     r_valid <= 1'b0;
                     r_state <= S0;
                  end
                  default: r_state <= S1;
               endcase
            end
            S2: begin
               // in_ready is low here, so only the drain path exists.
               if (w_hs) begin
                  r_head  <= r_tail;
                  r_state <= S1;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= S0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side consumer presenting a burst-framed valid/ready stream
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  rclk,
   input  logic                  r_rst,
   input  logic                  en,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  r_inc,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   localparam int                BEAT_W    = beat_width(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   logic              w_in_ready;
   logic              w_hs;
   logic [BEAT_W-1:0] r_beat;
   logic [CNT_WIDTH-1:0] r_word_cnt;

   // Gating with r_rst keeps the FIFO pointer still while reset is held.
   assign r_inc    = r_rst & en & ~EMPTY & w_in_ready;
   assign w_hs     = m_valid & m_ready;
   assign m_last   = m_valid & (r_beat == LAST_BEAT);
   assign word_cnt = r_word_cnt;

   reader_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (rclk),
      .rst_n     (r_rst),
      .in_valid  (r_inc),
      .in_data   (RD_DATA),
      .in_ready  (w_in_ready),
      .out_valid (m_valid),
      .out_data  (m_data),
      .out_ready (m_ready)
   );

   always_ff @(posedge rclk or negedge r_rst) begin
      if (!r_rst) begin
         r_beat     <= '0;
         r_word_cnt <= '0;
      end else if (w_hs) begin
         r_beat     <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
         r_word_cnt <= r_word_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader (burst 4 and burst 1 instances)
module tb_fifo_stream_reader;

   logic clk = 1'b0;
   logic rst_n, en, m_ready;
   int   checks = 0;
   int   failures = 0;

   always #10 clk = ~clk;

   logic [7:0] mem_a [256];
   int         wp_a = 0, rp_a = 0, hs_a = 0;
   logic [7:0] exp_a [$];
   logic       empty_a, r_inc_a, m_valid_a, m_last_a;
   logic [7:0] rd_a, m_data_a;
   logic [15:0] word_cnt_a;

   logic [7:0] mem_b [256];
   int         wp_b = 0, rp_b = 0, hs_b = 0;
   logic [7:0] exp_b [$];
   logic       empty_b, r_inc_b, m_valid_b, m_last_b;
   logic [7:0] rd_b, m_data_b;
   logic [3:0] word_cnt_b;

   assign empty_a = (wp_a == rp_a);
   assign rd_a    = mem_a[rp_a[7:0]];
   assign empty_b = (wp_b == rp_b);
   assign rd_b    = mem_b[rp_b[7:0]];

   fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) dut_a (
      .rclk(clk), .r_rst(rst_n), .en(en), .EMPTY(empty_a), .RD_DATA(rd_a),
      .r_inc(r_inc_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
      .m_last(m_last_a), .word_cnt(word_cnt_a)
   );

   fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(4)) dut_b (
      .rclk(clk), .r_rst(rst_n), .en(en), .EMPTY(empty_b), .RD_DATA(rd_b),
      .r_inc(r_inc_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
      .m_last(m_last_b), .word_cnt(word_cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_a(input logic [7:0] v);
      mem_a[wp_a[7:0]] = v;
      wp_a++;
      exp_a.push_back(v);
   endtask

   task automatic push_b(input logic [7:0] v);
      mem_b[wp_b[7:0]] = v;
      wp_b++;
      exp_b.push_back(v);
   endtask

   task automatic drain(input int bound);
      int k = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && k < bound) begin
         tick(1);
         k++;
      end
      chk("drain_a", 32'(exp_a.size()), 32'd0);
      chk("drain_b", 32'(exp_b.size()), 32'd0);
   endtask

   // FIFO models advance their read pointers on the pop strobe.
   always @(posedge clk) begin
      if (r_inc_a) begin
         chk("pop_while_empty_a", 32'(empty_a), 32'd0);
         rp_a <= rp_a + 1;
      end
      if (r_inc_b) begin
         chk("pop_while_empty_b", 32'(empty_b), 32'd0);
         rp_b <= rp_b + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && m_valid_a && m_ready) begin
         chk("exp_avail_a", 32'(exp_a.size() != 0), 32'd1);
         if (exp_a.size() != 0) chk("data_a", 32'(m_data_a), 32'(exp_a.pop_front()));
         chk("last_a", 32'(m_last_a), 32'((hs_a % 4) == 3));
         chk("cnt_a", 32'(word_cnt_a), 32'(hs_a[15:0]));
         hs_a++;
      end
      if (rst_n && m_valid_b && m_ready) begin
         chk("exp_avail_b", 32'(exp_b.size() != 0), 32'd1);
         if (exp_b.size() != 0) chk("data_b", 32'(m_data_b), 32'(exp_b.pop_front()));
         chk("last_b", 32'(m_last_b), 32'd1);
         chk("cnt_b", 32'(word_cnt_b), 32'(hs_b[3:0]));
         hs_b++;
      end
   end

   initial begin
      int base, rp_hold, rp0;
      rst_n   = 1'b0;
      en      = 1'b1;
      m_ready = 1'b1;
      tick(1);
      for (int i = 0; i < 9; i++) push_a(8'hA0 + 8'(i));
      for (int i = 0; i < 17; i++) push_b(8'h10 + 8'(i));
      #1;
      chk("rst_r_inc_a", 32'(r_inc_a), 32'd0);
      chk("rst_valid_a", 32'(m_valid_a), 32'd0);
      chk("rst_last_a", 32'(m_last_a), 32'd0);
      chk("rst_data_a", 32'(m_data_a), 32'd0);
      chk("rst_cnt_a", 32'(word_cnt_a), 32'd0);
      tick(1);
      rst_n = 1'b1;

      drain(60);
      chk("cnt_9_a", 32'(word_cnt_a), 32'd9);
      chk("cnt_wrap_b", 32'(word_cnt_b), 32'd1);

      m_ready = 1'b0;
      rp0 = rp_a;
      for (int i = 0; i < 4; i++) push_a(8'hB0 + 8'(i));
      tick(10);
      chk("bp_pops", 32'(rp_a - rp0), 32'd2);
      chk("bp_hold_data", 32'(m_data_a), 32'hB0);
      chk("bp_valid", 32'(m_valid_a), 32'd1);
      chk("bp_no_inc", 32'(r_inc_a), 32'd0);
      m_ready = 1'b1;
      tick(4);
      chk("bp_consecutive", 32'(exp_a.size()), 32'd0);

      for (int i = 0; i < 30; i++) push_a(8'h40 + 8'(i));
      for (int i = 0; i < 40; i++) begin
         m_ready = ~m_ready;
         tick(1);
      end
      m_ready = 1'b1;
      drain(60);
      chk("toggle_cnt", 32'(word_cnt_a), 32'(hs_a[15:0]));

      base = hs_a;
      for (int i = 0; i < 5; i++) push_a(8'hD0 + 8'(i));
      for (int k = 0; k < 20 && hs_a < base + 2; k++) tick(1);
      chk("en_two_hs", 32'(hs_a - base), 32'd2);
      en = 1'b0;
      #1;
      chk("en_off_inc", 32'(r_inc_a), 32'd0);
      rp_hold = rp_a;
      tick(5);
      chk("en_fifo_retains", 32'(rp_a), 32'(rp_hold));
      chk("en_buf_drained", 32'(exp_a.size()), 32'(wp_a - rp_a));
      chk("en_idle_valid", 32'(m_valid_a), 32'd0);
      en = 1'b1;
      drain(20);

      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_a(8'hE0 + 8'(i));
      tick(5);
      chk("pre_rst_valid", 32'(m_valid_a), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(m_valid_a), 32'd0);
      chk("async_last", 32'(m_last_a), 32'd0);
      chk("async_cnt", 32'(word_cnt_a), 32'd0);
      chk("async_inc", 32'(r_inc_a), 32'd0);
      void'(exp_a.pop_front());
      void'(exp_a.pop_front());
      hs_a = 0;
      hs_b = 0;
      tick(1);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      drain(20);
      chk("post_rst_cnt", 32'(word_cnt_a), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
